revaluate_engine: RTL
=====================

# revaluate_engine

Parametrised streaming successor to the single-shot revaluate datapath. It accepts one ROWS×COLS bit slice per valid/ready handshake and applies a programmable number of chi-style row rounds, one round per clock, or passes the slice through in bypass mode. It presents the result on a valid/ready output with a wrapping slice index and a last-slice flag. It sits between the slice reader and the slice writer, in place of the fixed reg25 + revaluate_func pair.

## Interface
- COLS, default 5: bits per row. Must be ≥ 3.
- ROWS, default 5: rows per slice. W = ROWS*COLS.
- SLICES, default 64: slices per frame. IW = max(1, clog2(SLICES)).
- MAX_ROUNDS, default 24: maximum round count. RW = clog2(MAX_ROUNDS+1).
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: input slice valid.
- in_ready, output, 1: engine can accept a slice.
- in_data, input, W: slice. Bit i = COLS*y + x, with x = column and y = row.
- in_mode, input, 1: 0 = bypass, 1 = chi. Sampled on accept.
- in_rounds, input, RW: number of rounds. Sampled on accept.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out_data, output, W: result slice.
- out_index, output, IW: frame position of this result.
- out_last, output, 1: out_index == SLICES-1.
- busy, output, 1: state ≠ IDLE.

## Operation
- FSM has three states.
  - IDLE: in_ready = 1. On in_valid, capture in_data, in_mode and in_rounds.
    - If in_mode = 0 or the effective rounds = 0, go to OUTPUT.
    - Otherwise go to COMPUTE, with the round counter = effective rounds.
  - COMPUTE: each cycle, data ← chi(data) and the counter decrements. When the counter reaches 1, go to OUTPUT on that edge.
  - OUTPUT: out_valid = 1. On out_ready, go to IDLE and advance the slice index.
- Effective rounds = min(in_rounds, MAX_ROUNDS). Values above MAX_ROUNDS are clamped, not rejected.
- chi definition: b[x,y] = a[x,y] ^ (~a[(x+1) mod COLS, y] & a[(x+2) mod COLS, y]).
  - Applies to every row independently.
  - Column indices wrap within the row.
- Bypass: out_data = the captured in_data, unchanged.
- Slice index:
  - Starts at 0.
  - Increments on each output handshake.
  - Wraps from SLICES-1 to 0.
  - out_last is decoded combinationally from the index.
- No overlap between slices: in_ready = 0 in COMPUTE and in OUTPUT.
- out_data and out_index are stable while out_valid = 1 and out_ready = 0.
- in_data, in_mode and in_rounds are ignored outside IDLE.

## Timing
- Reset (rst = 0, asynchronous) forces:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - out_data = 0
  - out_index = 0
  - out_last = 0 (1 when SLICES = 1)
  - busy = 0
  - round counter = 0
- Reset mid-COMPUTE or mid-OUTPUT discards the slice. No output handshake occurs and the index returns to 0.
- Latency, for an accept at edge E0 with R effective rounds in chi mode:
  - Rounds are applied at edges E1..ER.
  - out_valid rises after edge ER.
  - Bypass or R = 0: out_valid rises after E0.
- Output handshake at edge Eo: out_valid falls and in_ready rises after Eo.
- Peak throughput: one slice per R+2 cycles in chi mode, or one per 2 cycles in bypass mode.
- Deassertion of rst is expected synchronous to clk, handled by upstream synchronisers.

## Test plan
- Reset, then chi mode, R = 1, in_data = 25'h0000001 -> out_data = 25'h0000009 after 1 COMPUTE cycle, out_index = 0, out_last = 0.
- Chi mode, R = 2, in_data = 25'h0000001 -> out_data = 25'h0000003, out_valid rising after E2.
- Fixed points: 25'h1FFFFFF and 25'h0000000 with R = 24 -> output equals input. in_rounds = 31 with MAX_ROUNDS = 24 -> exactly 24 COMPUTE cycles.
- Bypass with in_rounds = 7 and in_data = 25'h0ABCDEF -> out_data = 25'h0ABCDEF one cycle after accept, zero COMPUTE cycles.
- Backpressure and wrap:
  - Hold out_ready = 0 for 5 cycles: out_data and out_index stay stable and in_ready = 0.
  - Stream 65 slices: out_last is high only at index 63, and the 65th output has index 0.
- Assert rst low mid-COMPUTE with R = 10 -> outputs take reset values immediately with no clock edge needed. The next slice gets out_index = 0.

Source files
------------

// File: rtl/revaluate_engine.sv
// Streaming slice engine: per-row chi rounds or bypass,
// with a wrapping frame index on a valid/ready output.
module revaluate_engine #(
  parameter int COLS       = 5,
  parameter int ROWS       = 5,
  parameter int SLICES     = 64,
  parameter int MAX_ROUNDS = 24,
  localparam int W  = ROWS * COLS,
  localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1,
  localparam int RW = $clog2(MAX_ROUNDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_mode,
  input  logic [RW-1:0] in_rounds,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_index,
  output logic          out_last,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    OUTPUT
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] eff_rounds;

  function automatic logic [W-1:0] chi(
    input logic [W-1:0] a
  );
    logic [W-1:0] b;
    b = '0;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        b[COLS*y+x] = a[COLS*y+x] ^
          (~a[COLS*y+((x+1)%COLS)] &
            a[COLS*y+((x+2)%COLS)]);
      end
    end
    return b;
  endfunction

  // Oversized round requests clamp rather than fault
  assign eff_rounds =
    (in_rounds > RW'(MAX_ROUNDS)) ?
      RW'(MAX_ROUNDS) : in_rounds;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d = in_data;
          if (!in_mode || eff_rounds == '0) begin
            state_d = OUTPUT;
          end else begin
            state_d = COMPUTE;
            cnt_d   = eff_rounds;
          end
        end
      end
      COMPUTE: begin
        data_d = chi(data_q);
        cnt_d  = cnt_q - RW'(1);
        if (cnt_q == RW'(1)) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
          idx_d   = (idx_q == IW'(SLICES - 1)) ?
                      '0 : idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign out_data  = data_q;
  assign out_index = idx_q;
  assign out_last  = (idx_q == IW'(SLICES - 1));
  assign busy      = (state_q != IDLE);

endmodule
